alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequences operations onto the shared 4-bit-opcode ALU and its decoder. Accepts one op request at a time over a valid/ready handshake and drives alu_op/operands. Waits a fixed latency for single-cycle ops and a longer one for muls. Returns result plus flags over a valid/ready response channel and flags illegal opcodes 10–15.

Parameters:
W, 8, operand/result width
MUL_CYCLES, 4, ALU cycles for muls (>=2)
OP_W, 4, opcode width (fixed at 4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  4  opcode: 0 neg, 1 andl, 2 equ, 3 orl, 4 dec, 5 add, 6 sub, 7 inc, 8 cmp, 9 muls, 10–15 illegal
req_a  in  W  operand A
req_b  in  W  operand B
alu_op  out  4  opcode to ALU decoder
alu_a  out  W  registered operand A
alu_b  out  W  registered operand B
alu_en  out  1  ALU operation active
alu_result  in  W  ALU result
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry/borrow flag
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_result  out  W  captured result (0 for illegal op)
resp_zero  out  1  captured zero flag
resp_carry  out  1  captured carry flag
resp_err  out  1  illegal opcode

Behaviour:
- States: IDLE, EXEC, MUL_WAIT, RESP. One-hot or binary encoding allowed.
- Reset (async, rst_n=0): state IDLE. req_ready=1. alu_en=0. alu_op=0. alu_a=alu_b=0. resp_valid=0. resp_result=0. resp_zero=resp_carry=resp_err=0. Mul counter=0.
- IDLE:
  - req_ready=1. Handshake when req_valid & req_ready.
  - On handshake, latch op, a, b into alu_op/alu_a/alu_b.
  - Op 0–8 -> EXEC. Op 9 -> MUL_WAIT with counter=MUL_CYCLES-1. Op 10–15 -> RESP with resp_err=1, result/flags=0, alu_en stays 0.
- EXEC: alu_en=1 for exactly one cycle. At the end of that cycle, capture alu_result/zero/carry into resp_* and go to RESP. Latency from accept to resp_valid is 2 cycles.
- MUL_WAIT:
  - alu_en=1 every cycle; counter decrements.
  - When counter==0, capture result and flags and go to RESP.
  - Latency from accept to resp_valid is MUL_CYCLES+1 cycles.
- RESP:
  - resp_valid=1. alu_en=0. req_ready=0. resp_* held stable until resp_valid & resp_ready.
  - On handshake, go to IDLE. resp_valid drops the next cycle. No new request is accepted in the same cycle as the response handshake.
- Throughput: at most one request per 3 cycles for single-cycle ops.
- alu_op/alu_a/alu_b hold their last value outside EXEC/MUL_WAIT; ALU outputs are don't-care when alu_en=0.
- resp_err clears on the next accepted legal request capture.
- Reset mid-operation: immediate return to reset values. The in-flight op is dropped with no response.
- req_op/req_a/req_b changes while req_ready=0 are ignored.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined:
  - Adds output ports perf_ops (16 bits), counting completed response handshakes, legal and illegal.
  - Adds output port perf_stall (16 bits), counting cycles with resp_valid=1 & resp_ready=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_NEG..OP_MULS (0–9) and OP_LAST_LEGAL=9;
  - sequencer state typedef/localparams IDLE/EXEC/MUL_WAIT/RESP;
  - default W.
- Sub-module alu_seq_cnt: a loadable down-counter for the MUL_WAIT latency, reused by the perf counters when the feature is enabled.

Test Plan:
- Reset mid-MUL_WAIT: pulse rst_n low during MUL_WAIT -> immediate IDLE, req_ready=1, resp_valid=0, no response emitted.
- Add, ready held high: op=5, a=8'h0F, b=8'h01, ALU model returns 8'h10 -> alu_en high 1 cycle, resp_valid 2 cycles after accept, resp_result=8'h10, resp_err=0.
- Multiply latency: op=9, a=3, b=5, MUL_CYCLES=4 -> alu_en high 4 consecutive cycles, resp_valid 5 cycles after accept, resp_result=15.
- Illegal opcodes: op=12 -> alu_en never asserts, resp_valid next cycle, resp_err=1, resp_result=0. Sweep op 0–15: resp_err=1 exactly for op 10–15.
- Response backpressure: resp_ready=0 for 10 cycles after cmp (op=8, a=b=8'h22) -> resp_result/resp_zero=1 stable, req_ready=0 throughout; a second req_valid pulse is not accepted. With ALU_SEQ_PERF_EN: perf_stall=10, perf_ops=1 after release.
- Back-to-back inc: op=7 issued 4 times with resp_ready=1 -> requests accepted every 3 cycles, 4 responses in order, no request dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants, sequencer
// state type and the default datapath width.
package alu_pkg;

  localparam int unsigned DEFAULT_W = 8;

  localparam logic [3:0] OP_NEG        = 4'd0;
  localparam logic [3:0] OP_ANDL       = 4'd1;
  localparam logic [3:0] OP_EQU        = 4'd2;
  localparam logic [3:0] OP_ORL        = 4'd3;
  localparam logic [3:0] OP_DEC        = 4'd4;
  localparam logic [3:0] OP_ADD        = 4'd5;
  localparam logic [3:0] OP_SUB        = 4'd6;
  localparam logic [3:0] OP_INC        = 4'd7;
  localparam logic [3:0] OP_CMP        = 4'd8;
  localparam logic [3:0] OP_MULS       = 4'd9;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_WAIT,
    RESP
  } seq_state_t;

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable down-counter that stops at zero. Used for the multiply latency
// and, inverted, as saturating up-counters for the performance counters.
module alu_seq_cnt #(
  parameter int unsigned           WIDTH   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  // Load has priority; decrement holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences single requests onto the shared ALU, waits the op latency and
// returns result/flags over a valid/ready response channel.
// Optional: define ALU_SEQ_PERF_EN to add perf_ops/perf_stall counters.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W          = DEFAULT_W,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned OP_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  output logic [OP_W-1:0] alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_en,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [W-1:0]    resp_result,
  output logic            resp_zero,
  output logic            resp_carry,
  output logic            resp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]     perf_ops,
  output logic [15:0]     perf_stall
`endif
);

  localparam int unsigned CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  seq_state_t    state, state_nx;
  logic          accept;
  logic          capture;
  logic          cnt_load;
  logic          cnt_dec;
  logic          req_legal;
  logic [CW-1:0] mul_cnt;

  assign req_legal = (req_op <= OP_LAST_LEGAL);

  alu_seq_cnt #(
    .WIDTH   (CW),
    .RST_VAL ('0)
  ) u_mul_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CW'(MUL_CYCLES - 1)),
    .dec      (cnt_dec),
    .count    (mul_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake/enable decode.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    alu_en     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_legal) begin
            state_nx = RESP;
          end else if (req_op == OP_MULS) begin
            cnt_load = 1'b1;
            state_nx = MUL_WAIT;
          end else begin
            state_nx = EXEC;
          end
        end
      end
      EXEC: begin
        alu_en   = 1'b1;
        capture  = 1'b1;
        state_nx = RESP;
      end
      MUL_WAIT: begin
        alu_en  = 1'b1;
        cnt_dec = 1'b1;
        if (mul_cnt == '0) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch on accept; result/flag capture at the end of the ALU window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_carry  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        alu_op <= req_op;
        alu_a  <= req_a;
        alu_b  <= req_b;
        if (!req_legal) begin
          resp_result <= '0;
          resp_zero   <= 1'b0;
          resp_carry  <= 1'b0;
          resp_err    <= 1'b1;
        end else begin
          resp_err <= 1'b0;
        end
      end
      if (capture) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_carry  <= alu_carry;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Perf counters run downward from all-ones; the inverted value is an
  // up-count that sticks at 16'hFFFF when the counter reaches zero.
  logic [15:0] ops_left;
  logic [15:0] stall_left;

  alu_seq_cnt #(
    .WIDTH   (16),
    .RST_VAL ('1)
  ) u_perf_ops (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .dec      (resp_valid & resp_ready),
    .count    (ops_left)
  );

  alu_seq_cnt #(
    .WIDTH   (16),
    .RST_VAL ('1)
  ) u_perf_stall (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .dec      (resp_valid & ~resp_ready),
    .count    (stall_left)
  );

  assign perf_ops   = ~ops_left;
  assign perf_stall = ~stall_left;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer with a behavioural ALU and a
// transaction-level reference for response contents and timing.
module tb_alu_op_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned MC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_en;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         alu_carry;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic         resp_zero;
  logic         resp_carry;
  logic         resp_err;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]  perf_ops;
  logic [15:0]  perf_stall;
`endif

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_ops   = 0;
  int exp_stall = 0;
  int cyc       = 0;
  int en_run;
  logic [31:0] noise;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .W          (W),
    .MUL_CYCLES (MC),
    .OP_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_en      (alu_en),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_carry  (resp_carry),
    .resp_err    (resp_err)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operation semantics: returns {err, carry, zero, result}.
  function automatic logic [W+2:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c;
    logic         e;
    c = 1'b0;
    e = 1'b0;
    wide = '0;
    case (op)
      4'd0: r = -a;
      4'd1: r = a & b;
      4'd2: r = ~(a ^ b);
      4'd3: r = a | b;
      4'd4: r = a - 1'b1;
      4'd5: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      4'd6, 4'd8: begin wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      4'd7: r = a + 1'b1;
      4'd9: r = W'(a * b);
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, c, (!e && r == '0), r};
  endfunction

  // ALU stand-in: outputs are only meaningful while enabled, and a multiply
  // only produces its answer in the last of its MC enabled cycles.
  logic [W+2:0] alu_f;
  logic         alu_good;
  assign alu_f      = alu_ref(alu_op, alu_a, alu_b);
  assign alu_good   = alu_en && (alu_op != 4'd9 || en_run == MC - 1);
  assign alu_result = alu_good ? alu_f[W-1:0] : noise[W-1:0];
  assign alu_zero   = alu_good ? alu_f[W]     : noise[W];
  assign alu_carry  = alu_good ? alu_f[W+1]   : noise[W+1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_run <= 0;
    else        en_run <= alu_en ? en_run + 1 : 0;
  end

  always @(posedge clk) begin
    noise <= $urandom;
    cyc   <= cyc + 1;
  end

  // One full transaction starting at a negedge with the DUT idle; ends at the
  // negedge after the response handshake.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W+2:0] exp;
    int lat, ens, exp_lat, exp_ens;
    exp = alu_ref(op, a, b);
    if (op > 4'd9)       begin exp_lat = 1;      exp_ens = 0;  end
    else if (op == 4'd9) begin exp_lat = MC + 1; exp_ens = MC; end
    else                 begin exp_lat = 2;      exp_ens = 1;  end
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    check("alu_op_latch", alu_op, op);
    check("alu_a_latch", alu_a, a);
    check("alu_b_latch", alu_b, b);
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 4'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    lat = 1;
    ens = 0;
    while (!resp_valid && lat < 20) begin
      ens += int'(alu_en);
      check("req_ready_busy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("alu_en_cycles", ens, exp_ens);
    for (int i = 0; i < stall; i++) begin
      check("stall_result", resp_result, exp[W-1:0]);
      check("stall_flags", {resp_err, resp_carry, resp_zero}, exp[W+2:W]);
      check("stall_ready", {req_ready, alu_en, resp_valid}, 3'b001);
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 4'($urandom);
      @(negedge clk);
    end
    exp_stall += stall;
    check("resp_valid", resp_valid, 1);
    check("resp_result", resp_result, exp[W-1:0]);
    check("resp_zero", resp_zero, exp[W]);
    check("resp_carry", resp_carry, exp[W+1]);
    check("resp_err", resp_err, exp[W+2]);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_ops++;
    check("post_hs_valid", resp_valid, 0);
    check("post_hs_ready", req_ready, 1);
    check("post_hs_op_held", alu_op, op);
    req_valid = 1'b0;
  endtask

  initial begin
    int t0;
    logic [3:0] rop;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_en", alu_en, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, '0);
    check("rst_resp", {resp_result, resp_zero, resp_carry, resp_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(4'd5, 8'h0F, 8'h01, 0);
    run_op(4'd9, 8'd3, 8'd5, 0);
    run_op(4'd12, 8'hAA, 8'h55, 0);
    run_op(4'd8, 8'h22, 8'h22, 10);
`ifdef ALU_SEQ_PERF_EN
    check("perf_stall_bp", perf_stall, 16'(exp_stall));
    check("perf_ops_bp", perf_ops, 16'(exp_ops));
`endif

    // Back-to-back increments: one accept every 3 cycles.
    t0 = cyc;
    for (int i = 0; i < 4; i++) run_op(4'd7, W'(i * 16 + 3), 8'h00, 0);
    check("b2b_cycles", cyc - t0, 12);

    // Opcode sweep, including all illegal codes.
    for (int op = 0; op < 16; op++) run_op(4'(op), W'($urandom), W'($urandom), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(rop, W'($urandom), W'($urandom), $urandom_range(0, 3));
    end
`ifdef ALU_SEQ_PERF_EN
    check("perf_ops", perf_ops, 16'(exp_ops));
    check("perf_stall", perf_stall, 16'(exp_stall));
`endif

    // Reset in the middle of a multiply drops it without a response.
    run_op(4'd5, 8'h30, 8'h07, 0);
    req_valid = 1'b1;
    req_op    = 4'd9;
    req_a     = 8'd7;
    req_b     = 8'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mul_busy", alu_en, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 1);
    check("midrst_valid", resp_valid, 0);
    check("midrst_en", alu_en, 0);
    check("midrst_alu", {alu_op, alu_a, alu_b}, '0);
    check("midrst_resp", {resp_result, resp_zero, resp_carry, resp_err}, '0);
    exp_ops   = 0;
    exp_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_resp", {resp_valid, alu_en, req_ready}, 3'b001);
    end
`ifdef ALU_SEQ_PERF_EN
    check("perf_rst", {perf_ops, perf_stall}, '0);
`endif
    run_op(4'd6, 8'h10, 8'h20, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
